// File: rtl/updown_counter.sv
// updown_counter: bounded up/down counter with load, clear, wrap/saturate mode,
// a combinational terminal-count flag, a one-cycle boundary pulse and a sticky boundary flag.
module updown_counter #(
  parameter int WIDTH    = 8,
  parameter int MAX_CNT  = 2**WIDTH-1,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic             enab,
  input  logic             up,
  input  logic [WIDTH-1:0] cnt_in,
  output logic [WIDTH-1:0] cnt_out,
  output logic             tc,
  output logic             wrap_p,
  output logic             bnd_flag
);
  localparam logic [WIDTH-1:0] MAX = WIDTH'(MAX_CNT);
  logic [WIDTH-1:0] cnt_nxt;
  assign tc = enab & ~load & ~clr & ((up & (cnt_out == MAX)) | (~up & (cnt_out == '0)));
  // tc doubles as the boundary-event strobe: it already excludes clr and load
  always_comb begin
    cnt_nxt = clr   ? '0 :
              load  ? ((cnt_in > MAX) ? MAX : cnt_in) :
              !enab ? cnt_out :
              tc    ? ((SATURATE != 0) ? cnt_out : (up ? '0 : MAX)) :
              up    ? cnt_out + 1'b1 : cnt_out - 1'b1;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_out  <= '0;
      wrap_p   <= 1'b0;
      bnd_flag <= 1'b0;
    end else begin
      cnt_out  <= cnt_nxt;
      wrap_p   <= tc;
      bnd_flag <= ~clr & (bnd_flag | tc);
    end
  end
endmodule
